fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 imem_en  out  1  read enable to instruction memory.
REQ-005 pc_addr  out  32  byte address presented to instruction memory.
REQ-006 instr_in  in  32  memory read data, valid the cycle after imem_en=1.
REQ-007 redirect_valid  in  1  branch/jump/trap redirect request.
REQ-008 redirect_addr  in  32  redirect target byte address.
REQ-009 fetch_valid  out  1  decode-side instruction valid.
REQ-010 fetch_ready  in  1  decode-side ready; transfer when fetch_valid & fetch_ready.
REQ-011 fetch_instr  out  32  instruction at FIFO head.
REQ-012 fetch_pc  out  32  byte address of fetch_instr.
REQ-013 fetch_fault  out  1  misaligned-redirect fault flag (REQ-029).

Function
REQ-014 Memory read latency is exactly 1 cycle; controller tracks one in-flight read (flag + its pc).
REQ-015 Returned data and its pc are written into a 2-entry FIFO the cycle instr_in is valid, unless squashed.
REQ-016 imem_en = 1 in state RUN when (fifo_count + inflight - pop) < 2, pop = fetch_valid & fetch_ready; else 0.
REQ-017 pc_addr is registered; advances by 4 on each cycle imem_en=1, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-018 fetch_valid = FIFO non-empty; fetch_instr/fetch_pc driven from FIFO head, stable while fetch_valid & !fetch_ready.
REQ-019 With fetch_ready held 1, steady-state throughput is one instruction per cycle.
REQ-020 FSM states: RUN, REDIR, FAULT.
REQ-021 RUN -> REDIR on redirect_valid: FIFO flushed, in-flight read squashed, pc_addr <= redirect_addr, imem_en=0 that cycle.
REQ-022 REDIR -> RUN after one cycle; redirect_valid in REDIR reloads pc_addr and stays in REDIR.
REQ-023 Redirect and pop in same cycle: redirect wins; popped entry counts as transferred, all others discarded.
REQ-024 First fetch_valid after reset release: cycle 2; after redirect: 3 cycles after the redirect cycle.
REQ-025 FIFO never overflows: data returning with fifo_count=2 cannot occur by REQ-016.

Reset
REQ-026 rst asserted: state=RUN, pc_addr=RESET_PC, FIFO empty, inflight=0, fetch_fault=0; imem_en=0, fetch_valid=0 while rst=1.
REQ-027 rst mid-operation discards FIFO contents and in-flight read immediately; no stale data surfaces after release.
REQ-028 imem_en may assert in the first cycle after rst deasserts.

Configuration
REQ-029 FETCH_MISALIGN_CHK_EN defined: redirect with redirect_addr[1:0]!=0 -> FAULT; FIFO flushed, imem_en=0, fetch_fault=1 until rst.
REQ-030 FETCH_MISALIGN_CHK_EN undefined: redirect_addr[1:0] forced to 2'b00, FAULT unreachable, fetch_fault tied 0.

Structure
REQ-031 Shared package holds FSM state enum, INSTR_W=32, ADDR_W=32, PC_STEP=4, FIFO_DEPTH=2.
REQ-032 FIFO is sub-module fetch_fifo (2-entry, {pc,instr} payload, flush input); FSM and issue logic stay in fetch_ctrl.

Verification
REQ-033 Reset release, ready=1, ROM word[n]=n -> fetch_valid from cycle 2, fetch_pc 0,4,8..., fetch_instr 0,1,2..., no bubbles.
REQ-034 Ready=0 for 5 cycles after first valid -> imem_en stops after 2 entries held; resume yields pc 0,4,8 in order, none lost/duplicated.
REQ-035 Redirect to 32'h100 while FIFO full -> valid drops next cycle; next fetch_pc=32'h100 three cycles later; no pre-redirect instr appears.
REQ-036 Start pc 32'hFFFF_FFF8, ready=1 -> fetch_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 With macro, redirect to 32'h102 -> fetch_fault=1, imem_en=0, fetch_valid=0 until rst; without macro -> fetch_pc=32'h100.
REQ-038 rst pulsed with FIFO full and read in flight -> all outputs at reset values; after release first fetch_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module   : fetch_ctrl_pkg
// Purpose  : Shared types and constants for the instruction fetch controller.
//            Holds the FSM state encoding, datapath widths, the PC increment
//            and the depth of the fetch FIFO.
// Revision : 1.0 - initial release
//============================================================================
package fetch_ctrl_pkg;

   localparam int INSTR_W     = 32;
   localparam int ADDR_W      = 32;
   localparam int FIFO_DEPTH  = 2;
   localparam int FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int FIFO_DATA_W = ADDR_W + INSTR_W;

   localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_REDIR = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

   // Sequential fetch address; wraps naturally modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
//============================================================================
// Module   : fetch_fifo
// Purpose  : 2-entry FIFO carrying {pc, instr} from the memory return path
//            to the decode interface. Flush empties it in one cycle and
//            takes priority over push and pop.
// Ports    : clk, rst        - clock, async active-high reset
//            flush           - discard all entries
//            push, push_data - write one entry
//            pop             - consume the head entry
//            valid           - FIFO non-empty
//            head_data       - entry at the head
//            count           - number of stored entries
// Revision : 1.0 - initial release
//============================================================================
module fetch_fifo
   import fetch_ctrl_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_W-1:0]     push_data,
   input  logic                  pop,
   output logic                  valid,
   output logic [DATA_W-1:0]     head_data,
   output logic [FIFO_CNT_W-1:0] count
);

   // Single-bit pointers: the storage is exactly two entries deep.
   logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [FIFO_CNT_W-1:0] r_count;

   logic                  w_do_pop;
   logic                  w_do_push;

   assign w_do_pop  = pop && (r_count != '0);
   // A push into a full FIFO is only accepted when the head leaves the same cycle.
   assign w_do_push = push && ((r_count != FIFO_CNT_W'(FIFO_DEPTH)) || w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + FIFO_CNT_W'(w_do_push) - FIFO_CNT_W'(w_do_pop);
      end
   end

   // Payload storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (w_do_push && !flush) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   assign valid     = (r_count != '0);
   assign head_data = r_mem[r_rd_ptr];
   assign count     = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
//============================================================================
// Module   : fetch_ctrl
// Purpose  : Instruction fetch controller. Issues sequential reads to a
//            1-cycle-latency instruction memory, buffers returned words with
//            their pc in a 2-entry FIFO and presents them to decode over a
//            valid/ready handshake. Redirects flush buffered and in-flight
//            work and restart fetching at the new target.
// Config   : FETCH_MISALIGN_CHK_EN - when defined, a redirect to a non
//            word-aligned address parks the controller in FAULT (fetch_fault
//            held until rst). When undefined, the low two target bits are
//            cleared and fetch_fault is tied low.
// Ports    : clk, rst                    - clock, async active-high reset
//            imem_en, pc_addr, instr_in  - instruction memory interface
//            redirect_valid/addr         - branch/jump/trap redirect
//            fetch_valid/ready           - decode handshake
//            fetch_instr, fetch_pc       - FIFO head payload
//            fetch_fault                 - misaligned redirect fault flag
// Revision : 1.0 - initial release
//============================================================================
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_en,
   output logic [ADDR_W-1:0]  pc_addr,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic               fetch_valid,
   input  logic               fetch_ready,
   output logic [INSTR_W-1:0] fetch_instr,
   output logic [ADDR_W-1:0]  fetch_pc,
   output logic               fetch_fault
);

   fetch_state_e          r_state;
   fetch_state_e          w_state_next;

   logic [ADDR_W-1:0]     r_pc_addr;
   logic                  r_inflight;
   logic [ADDR_W-1:0]     r_inflight_pc;

   logic [ADDR_W-1:0]     w_redir_addr;
   logic                  w_misalign;
   logic                  w_redir_take;
   logic                  w_flush;
   logic                  w_issue;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_room;
   logic [FIFO_CNT_W:0]   w_occ;

   logic                  w_fifo_valid;
   logic [FIFO_DATA_W-1:0] w_head;
   logic [FIFO_CNT_W-1:0] w_count;

`ifdef FETCH_MISALIGN_CHK_EN
   assign w_redir_addr = redirect_addr;
   assign w_misalign   = (redirect_addr[1:0] != 2'b00);
`else
   assign w_redir_addr = redirect_addr & ~ADDR_W'(3);
   assign w_misalign   = 1'b0;
`endif

   // FAULT is terminal until reset, so redirects there are ignored.
   assign w_redir_take = redirect_valid && (r_state != ST_FAULT);

   assign fetch_valid  = w_fifo_valid && !rst;
   assign w_pop        = fetch_valid && fetch_ready;

   // Entries the FIFO will hold once the outstanding read lands and the
   // current pop retires; issue only if that leaves a free slot.
   assign w_occ  = {1'b0, w_count} + (FIFO_CNT_W+1)'(r_inflight) - (FIFO_CNT_W+1)'(w_pop);
   assign w_room = (w_occ < (FIFO_CNT_W+1)'(FIFO_DEPTH));

   // REDIR also issues: the FIFO is empty and nothing is in flight, and
   // fetching the target there gives first valid three cycles after the
   // redirect.
   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_flush      = 1'b0;
      case (r_state)
         ST_RUN, ST_REDIR: begin
            if (redirect_valid) begin
               w_flush      = 1'b1;
               w_state_next = w_misalign ? ST_FAULT : ST_REDIR;
            end else begin
               w_state_next = ST_RUN;
               w_issue      = w_room;
            end
         end
         ST_FAULT: begin
            w_flush = 1'b1;
         end
         default: begin
            w_state_next = ST_RUN;
         end
      endcase
   end

   assign imem_en = w_issue && !rst;
   // Returning data is squashed whenever the FIFO is being flushed.
   assign w_push  = r_inflight && !w_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_pc_addr     <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= RESET_PC;
      end else begin
         r_state    <= w_state_next;
         r_inflight <= imem_en;
         if (w_redir_take) begin
            r_pc_addr <= w_redir_addr;
         end else if (imem_en) begin
            r_pc_addr <= next_pc(r_pc_addr);
         end
         if (imem_en) begin
            r_inflight_pc <= r_pc_addr;
         end
      end
   end

   fetch_fifo #(
      .DATA_W (FIFO_DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (w_flush),
      .push      (w_push),
      .push_data ({r_inflight_pc, instr_in}),
      .pop       (w_pop),
      .valid     (w_fifo_valid),
      .head_data (w_head),
      .count     (w_count)
   );

   assign pc_addr     = r_pc_addr;
   assign fetch_pc    = w_head[FIFO_DATA_W-1 -: ADDR_W];
   assign fetch_instr = w_head[INSTR_W-1:0];

`ifdef FETCH_MISALIGN_CHK_EN
   assign fetch_fault = (r_state == ST_FAULT);
`else
   assign fetch_fault = 1'b0;
`endif

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Self-checking bench for fetch_ctrl. Instruction memory returns
//            word[n] = n (pc >> 2) one cycle after imem_en. Expected decode
//            transfers are queued by the stimulus and checked by a monitor.
// Revision : 1.0 - initial release
//============================================================================
module tb_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_en;
   logic [31:0] pc_addr;
   logic [31:0] instr_in = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_addr = 32'h0;
   logic        fetch_valid;
   logic        fetch_ready = 1'b0;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;
   logic        fetch_fault;

   int errors = 0;
   int checks = 0;
   logic [63:0] sb [$];

   fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_en        (imem_en),
      .pc_addr        (pc_addr),
      .instr_in       (instr_in),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .fetch_valid    (fetch_valid),
      .fetch_ready    (fetch_ready),
      .fetch_instr    (fetch_instr),
      .fetch_pc       (fetch_pc),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   // Instruction memory: 1-cycle read latency, word[n] = n.
   always @(posedge clk) begin
      if (imem_en) instr_in <= pc_addr >> 2;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void exp_push(input logic [31:0] pc);
      sb.push_back({pc, pc >> 2});
   endfunction

   // Step until every queued transfer has been seen; the cycle count taken
   // exposes latency and bubbles.
   task automatic drain(input string name, input int exp_cycles);
      int cyc = 0;
      while (sb.size() != 0 && cyc < 100) begin
         step();
         cyc++;
      end
      check(name, 32'(cyc), 32'(exp_cycles));
   endtask

   // Monitor: every decode transfer must match the head of the scoreboard.
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         if (!rst && fetch_valid && fetch_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got pc=%h instr=%h expected no transfer",
                        fetch_pc, fetch_instr);
            end else begin
               exp = sb.pop_front();
               if ({fetch_pc, fetch_instr} !== exp) begin
                  errors++;
                  $display("FAIL sb_transfer: got pc=%h instr=%h expected pc=%h instr=%h",
                           fetch_pc, fetch_instr, exp[63:32], exp[31:0]);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state and streaming from reset with ready held high.
      fetch_ready = 1'b1;
      repeat (3) step();
      check("rst_imem_en",  {31'b0, imem_en},     32'd0);
      check("rst_valid",    {31'b0, fetch_valid}, 32'd0);
      check("rst_fault",    {31'b0, fetch_fault}, 32'd0);
      check("rst_pc_addr",  pc_addr,              RESET_PC);
      for (int i = 0; i < 8; i++) exp_push(RESET_PC + 32'(4 * i));
      rst = 1'b0;
      #1;
      check("rel_imem_en", {31'b0, imem_en}, 32'd1);
      drain("stream_cycles", 10);
      fetch_ready = 1'b0;
      step();
      step();
      check("hold_imem_en", {31'b0, imem_en}, 32'd0);
      check("hold_head_pc", fetch_pc, 32'd32);

      // Back-pressure from reset: two entries held, nothing lost on resume.
      rst = 1'b1;
      #1;
      check("rst2_valid",   {31'b0, fetch_valid}, 32'd0);
      check("rst2_pc_addr", pc_addr,              RESET_PC);
      step();
      exp_push(32'd0);
      exp_push(32'd4);
      exp_push(32'd8);
      rst = 1'b0;
      step();
      step();
      check("bp_first_valid", {31'b0, fetch_valid}, 32'd1);
      check("bp_first_pc",    fetch_pc,             32'd0);
      step();
      step();
      check("bp_imem_stop",   {31'b0, imem_en},     32'd0);
      step();
      step();
      check("bp_head_stable", fetch_pc,             32'd0);
      step();
      fetch_ready = 1'b1;
      drain("bp_resume_cycles", 3);
      fetch_ready = 1'b0;
      step();
      step();

      // Redirect with FIFO full, coinciding with a pop of the head.
      check("redir_head_pc", fetch_pc, 32'd12);
      exp_push(32'd12);
      exp_push(32'h100);
      exp_push(32'h104);
      exp_push(32'h108);
      fetch_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_addr  = 32'h100;
      #1;
      check("redir_imem_en", {31'b0, imem_en}, 32'd0);
      step();
      redirect_valid = 1'b0;
      check("redir_drop1", {31'b0, fetch_valid}, 32'd0);
      step();
      check("redir_drop2", {31'b0, fetch_valid}, 32'd0);
      step();
      check("redir_valid", {31'b0, fetch_valid}, 32'd1);
      check("redir_pc",    fetch_pc,             32'h100);
      drain("redir_cycles", 3);
      fetch_ready = 1'b0;

      // Address wrap at the top of the 32-bit space.
      exp_push(32'hFFFF_FFF8);
      exp_push(32'hFFFF_FFFC);
      exp_push(32'h0000_0000);
      redirect_valid = 1'b1;
      redirect_addr  = 32'hFFFF_FFF8;
      step();
      redirect_valid = 1'b0;
      fetch_ready    = 1'b1;
      drain("wrap_cycles", 5);
      fetch_ready = 1'b0;

      // Misaligned redirect.
`ifndef FETCH_MISALIGN_CHK_EN
      exp_push(32'h100);
`endif
      redirect_valid = 1'b1;
      redirect_addr  = 32'h102;
      step();
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      check("mis_fault",   {31'b0, fetch_fault}, 32'd1);
      check("mis_imem_en", {31'b0, imem_en},     32'd0);
      step();
      step();
      step();
      check("mis_valid_hold", {31'b0, fetch_valid}, 32'd0);
      check("mis_fault_hold", {31'b0, fetch_fault}, 32'd1);
      check("mis_imem_hold",  {31'b0, imem_en},     32'd0);
`else
      check("mis_fault", {31'b0, fetch_fault}, 32'd0);
      step();
      step();
      check("mis_valid", {31'b0, fetch_valid}, 32'd1);
      check("mis_pc",    fetch_pc,             32'h100);
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
      check("mis_sb_empty", 32'(sb.size()), 32'd0);
`endif

      // Reset pulse with buffered and in-flight work.
      rst = 1'b1;
      #1;
      check("rst3_valid",   {31'b0, fetch_valid}, 32'd0);
      check("rst3_imem_en", {31'b0, imem_en},     32'd0);
      check("rst3_fault",   {31'b0, fetch_fault}, 32'd0);
      check("rst3_pc_addr", pc_addr,              RESET_PC);
      step();
      exp_push(RESET_PC);
      exp_push(RESET_PC + 32'd4);
      rst         = 1'b0;
      fetch_ready = 1'b1;
      drain("rst3_cycles", 4);
      fetch_ready = 1'b0;

      repeat (3) step();
      check("end_sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fetch_ctrl
`default_nettype wire
